// File: rtl/vend_pkg.sv
// vend_pkg: shared types and helpers for the vending controller.
//   state_e  - controller FSM states
//   total_w  - width of summed-price / change values
//   sat_add  - unsigned add clipped to an upper limit
package vend_pkg;

    typedef enum logic [2:0] {
        StSelect,
        StCheck,
        StPay,
        StVend,
        StRefund
    } state_e;

    // A sum of n_items prices of credit_w bits never exceeds credit_w + clog2(n_items) bits.
    function automatic int unsigned total_w(input int unsigned n_items,
                                            input int unsigned credit_w);
        return credit_w + $clog2(n_items);
    endfunction

    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned limit);
        int unsigned s;
        s = a + b;
        return (s > limit) ? limit : s;
    endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// vend_ctrl_if: front-panel bus of the vending controller.
//   master modport - selection/coin/restock stimulus out, status in (debouncers/display side)
//   slave modport  - the controller itself
interface vend_ctrl_if
    import vend_pkg::*;
#(
    parameter int unsigned N_ITEMS  = 4,
    parameter int unsigned CREDIT_W = 8,
    parameter int unsigned STOCK_W  = 6
);
    localparam int unsigned TOTAL_W = total_w(N_ITEMS, CREDIT_W);
    localparam int unsigned IDX_W   = $clog2(N_ITEMS);

    logic [N_ITEMS*CREDIT_W-1:0] price;
    logic [N_ITEMS-1:0]          sel_mask;
    logic                        confirm;
    logic                        cancel;
    logic                        coin_valid;
    logic [CREDIT_W-1:0]         coin_value;
    logic                        restock_valid;
    logic [IDX_W-1:0]            restock_idx;
    logic [STOCK_W-1:0]          restock_qty;

    logic [CREDIT_W-1:0]         credit;
    logic [TOTAL_W-1:0]          total_due;
    logic [TOTAL_W-1:0]          change;
    logic                        change_valid;
    logic [N_ITEMS-1:0]          vend_mask;
    logic                        vend_valid;
    logic                        sold_out;
    logic                        short_funds;
    logic                        coin_reject;
    logic [N_ITEMS*STOCK_W-1:0]  stock;
    logic                        busy;

    modport master (
        output price, sel_mask, confirm, cancel, coin_valid, coin_value,
               restock_valid, restock_idx, restock_qty,
        input  credit, total_due, change, change_valid, vend_mask, vend_valid,
               sold_out, short_funds, coin_reject, stock, busy
    );

    modport slave (
        input  price, sel_mask, confirm, cancel, coin_valid, coin_value,
               restock_valid, restock_idx, restock_qty,
        output credit, total_due, change, change_valid, vend_mask, vend_valid,
               sold_out, short_funds, coin_reject, stock, busy
    );

endinterface

// File: rtl/vend_stock_bank.sv
// vend_stock_bank: per-item stock counters.
//   clk, reset     - clock, asynchronous active-high reset (loads INIT_STOCK)
//   restock_*      - add restock_qty to item restock_idx, saturating; idx >= N_ITEMS ignored
//   dec_mask       - decrement every flagged item by one this cycle
//   stock          - packed counters, item i at [i*STOCK_W +: STOCK_W]
//   zero           - per-item "stock is 0" flags
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int unsigned N_ITEMS    = 4,
    parameter int unsigned STOCK_W    = 6,
    parameter int unsigned INIT_STOCK = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       restock_valid,
    input  logic [$clog2(N_ITEMS)-1:0] restock_idx,
    input  logic [STOCK_W-1:0]         restock_qty,
    input  logic [N_ITEMS-1:0]         dec_mask,
    output logic [N_ITEMS*STOCK_W-1:0] stock,
    output logic [N_ITEMS-1:0]         zero
);

    localparam int unsigned StockMax = (32'd1 << STOCK_W) - 32'd1;

    logic [STOCK_W-1:0] cnt_q [N_ITEMS];
    logic [STOCK_W-1:0] cnt_d [N_ITEMS];
    logic [STOCK_W-1:0] add   [N_ITEMS];

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            add[i] = (restock_valid && (int'(restock_idx) == i)) ? restock_qty : '0;
            // Decrement before clipping so that stock + qty - 1 saturates as one value.
            if (dec_mask[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = STOCK_W'(sat_add(32'(cnt_q[i]) - 32'd1, 32'(add[i]), StockMax));
            end else begin
                cnt_d[i] = STOCK_W'(sat_add(32'(cnt_q[i]), 32'(add[i]), StockMax));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                cnt_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            stock[i*STOCK_W +: STOCK_W] = cnt_q[i];
            zero[i]                     = (cnt_q[i] == '0);
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending controller top.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - vend_ctrl_if.slave: selection, coins, restock in; credit, due, change,
//                dispense/status pulses, stock and busy out (all registered)
// Flow: SELECT -> CHECK -> PAY -> VEND / REFUND -> SELECT. Dispense and change pulses are
// issued on the edge that enters VEND/REFUND; those states then clear the transaction.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned N_ITEMS     = 4,
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned STOCK_W     = 6,
    parameter int unsigned INIT_STOCK  = 3,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input logic        clk,
    input logic        reset,
    vend_ctrl_if.slave bus
);

    localparam int unsigned TOTAL_W = total_w(N_ITEMS, CREDIT_W);
    localparam int unsigned TimerW  = $clog2(TIMEOUT_CYC);

    state_e               state_q, state_d;
    logic [N_ITEMS-1:0]   sel_q, sel_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [TOTAL_W-1:0]   total_due_q, total_due_d;
    logic [TOTAL_W-1:0]   change_q, change_d;
    logic                 change_valid_q, change_valid_d;
    logic [N_ITEMS-1:0]   vend_mask_q, vend_mask_d;
    logic                 vend_valid_q, vend_valid_d;
    logic                 sold_out_q, sold_out_d;
    logic                 short_funds_q, short_funds_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 busy_q;
    logic [TimerW-1:0]    timer_q, timer_d;

    logic [N_ITEMS-1:0]   dec_mask;
    logic [N_ITEMS-1:0]   stock_zero;
    logic [CREDIT_W:0]    coin_sum;
    logic [CREDIT_W-1:0]  credit_acc;
    logic [TOTAL_W-1:0]   price_sum;
    logic                 take_coin;
    logic                 go_refund;

    vend_stock_bank #(
        .N_ITEMS    (N_ITEMS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock_bank (
        .clk           (clk),
        .reset         (reset),
        .restock_valid (bus.restock_valid),
        .restock_idx   (bus.restock_idx),
        .restock_qty   (bus.restock_qty),
        .dec_mask      (dec_mask),
        .stock         (bus.stock),
        .zero          (stock_zero)
    );

    assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};

    always_comb begin
        price_sum = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel_q[i]) begin
                price_sum = price_sum + TOTAL_W'(bus.price[i*CREDIT_W +: CREDIT_W]);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        total_due_d    = total_due_q;
        change_d       = change_q;
        change_valid_d = 1'b0;
        vend_mask_d    = vend_mask_q;
        vend_valid_d   = 1'b0;
        sold_out_d     = 1'b0;
        short_funds_d  = 1'b0;
        coin_reject_d  = 1'b0;
        timer_d        = timer_q;
        dec_mask       = '0;
        go_refund      = 1'b0;
        credit_acc     = credit_q;

        // A coin arriving with cancel in CHECK/PAY is dropped silently.
        take_coin = bus.coin_valid &&
                    !(bus.cancel && ((state_q == StCheck) || (state_q == StPay)));
        if (take_coin) begin
            if ((state_q == StVend) || (state_q == StRefund) || coin_sum[CREDIT_W]) begin
                coin_reject_d = 1'b1;
            end else begin
                credit_acc = coin_sum[CREDIT_W-1:0];
            end
        end
        credit_d = credit_acc;

        unique case (state_q)
            StSelect: begin
                if (bus.cancel) begin
                    sel_d = '0;
                end else begin
                    sel_d = sel_q | bus.sel_mask;
                    if (bus.confirm && ((sel_q | bus.sel_mask) != '0)) begin
                        state_d  = StCheck;
                        change_d = '0;
                    end
                end
            end
            StCheck: begin
                total_due_d = price_sum;
                if (bus.cancel) begin
                    go_refund = 1'b1;
                end else if ((sel_q & stock_zero) != '0) begin
                    sold_out_d = 1'b1;
                    go_refund  = 1'b1;
                end else begin
                    state_d = StPay;
                    timer_d = '0;
                end
            end
            StPay: begin
                if (bus.cancel) begin
                    go_refund = 1'b1;
                end else if (bus.confirm) begin
                    timer_d = '0;
                    if (TOTAL_W'(credit_acc) >= total_due_q) begin
                        state_d        = StVend;
                        vend_valid_d   = 1'b1;
                        vend_mask_d    = sel_q;
                        change_d       = TOTAL_W'(credit_acc) - total_due_q;
                        change_valid_d = 1'b1;
                    end else begin
                        short_funds_d = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    timer_d = '0;
                end else if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
                    go_refund = 1'b1;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StVend: begin
                dec_mask    = sel_q;
                credit_d    = '0;
                sel_d       = '0;
                total_due_d = '0;
                state_d     = StSelect;
            end
            StRefund: begin
                credit_d    = '0;
                sel_d       = '0;
                total_due_d = '0;
                state_d     = StSelect;
            end
            default: state_d = StSelect;
        endcase

        if (go_refund) begin
            state_d        = StRefund;
            change_d       = TOTAL_W'(credit_acc);
            change_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StSelect;
            sel_q          <= '0;
            credit_q       <= '0;
            total_due_q    <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            vend_mask_q    <= '0;
            vend_valid_q   <= 1'b0;
            sold_out_q     <= 1'b0;
            short_funds_q  <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            credit_q       <= credit_d;
            total_due_q    <= total_due_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            vend_mask_q    <= vend_mask_d;
            vend_valid_q   <= vend_valid_d;
            sold_out_q     <= sold_out_d;
            short_funds_q  <= short_funds_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= (state_d != StSelect);
            timer_q        <= timer_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.total_due    = total_due_q;
    assign bus.change       = change_q;
    assign bus.change_valid = change_valid_q;
    assign bus.vend_mask    = vend_mask_q;
    assign bus.vend_valid   = vend_valid_q;
    assign bus.sold_out     = sold_out_q;
    assign bus.short_funds  = short_funds_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed bench for vend_ctrl. Expected change amounts and dispense masks are
// queued when a transaction is driven and consumed whenever the DUT pulses change_valid or
// vend_valid; other results are checked inline.
module tb_vend_ctrl;
    import vend_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned SW   = 6;
    localparam int unsigned INIT = 3;
    localparam int unsigned TO   = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vend_ctrl_if #(.N_ITEMS(N), .CREDIT_W(CW), .STOCK_W(SW)) bus ();

    vend_ctrl #(
        .N_ITEMS     (N),
        .CREDIT_W    (CW),
        .STOCK_W     (SW),
        .INIT_STOCK  (INIT),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int sf_cnt   = 0;
    int so_cnt   = 0;
    int cr_cnt   = 0;
    logic [31:0] exp_change_q[$];
    logic [31:0] exp_vend_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] stock_of(input int i);
        return 32'(bus.stock[i*SW +: SW]);
    endfunction

    // Advance one clock and sample 1 time unit after the edge; consume scoreboard entries.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.change_valid) begin
            if (exp_change_q.size() == 0) chk("change_unexpected", 32'(bus.change_valid), 0);
            else chk("change", 32'(bus.change), exp_change_q.pop_front());
        end
        if (bus.vend_valid) begin
            if (exp_vend_q.size() == 0) chk("vend_unexpected", 32'(bus.vend_valid), 0);
            else chk("vend_mask", 32'(bus.vend_mask), exp_vend_q.pop_front());
        end
        if (bus.short_funds) sf_cnt++;
        if (bus.sold_out) so_cnt++;
        if (bus.coin_reject) cr_cnt++;
    endtask

    task automatic coin(input int v);
        bus.coin_valid = 1'b1;
        bus.coin_value = CW'(v);
        cyc();
        bus.coin_valid = 1'b0;
    endtask

    // Select items, confirm, and step through CHECK (leaves the DUT in PAY or REFUND).
    task automatic select(input logic [N-1:0] mask);
        bus.sel_mask = mask;
        cyc();
        bus.sel_mask = '0;
        bus.confirm  = 1'b1;
        cyc();
        bus.confirm  = 1'b0;
        chk("check_busy", 32'(bus.busy), 1);
        cyc();
    endtask

    task automatic pay_confirm();
        bus.confirm = 1'b1;
        cyc();
        bus.confirm = 1'b0;
    endtask

    task automatic restock(input int idx, input int qty);
        bus.restock_valid = 1'b1;
        bus.restock_idx   = 2'(idx);
        bus.restock_qty   = SW'(qty);
        cyc();
        bus.restock_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;
        reset             = 1'b1;
        bus.price         = {8'd3, 8'd3, 8'd2, 8'd2};
        bus.sel_mask      = '0;
        bus.confirm       = 1'b0;
        bus.cancel        = 1'b0;
        bus.coin_valid    = 1'b0;
        bus.coin_value    = '0;
        bus.restock_valid = 1'b0;
        bus.restock_idx   = '0;
        bus.restock_qty   = '0;
        repeat (2) cyc();
        chk("rst_credit", 32'(bus.credit), 0);
        chk("rst_due", 32'(bus.total_due), 0);
        chk("rst_change", 32'(bus.change), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        for (int i = 0; i < N; i++) chk("rst_stock", stock_of(i), INIT);
        reset = 1'b0;
        cyc();

        // Items 0+2 for exactly 5: no change, stock of both drops.
        select(4'b0101);
        chk("t1_due", 32'(bus.total_due), 5);
        coin(5);
        chk("t1_credit", 32'(bus.credit), 5);
        exp_change_q.push_back(0);
        exp_vend_q.push_back(32'b0101);
        pay_confirm();
        chk("t1_vend_latency", 32'(bus.vend_valid), 1);
        cyc();
        chk("t1_stock0", stock_of(0), 2);
        chk("t1_stock2", stock_of(2), 2);
        chk("t1_credit_clr", 32'(bus.credit), 0);
        chk("t1_idle", 32'(bus.busy), 0);

        // Item1 paid in single units with an early confirm.
        select(4'b0010);
        chk("t2_due", 32'(bus.total_due), 2);
        coin(1);
        pay_confirm();
        chk("t2_short_pulse", 32'(bus.short_funds), 1);
        coin(1);
        coin(1);
        coin(1);
        chk("t2_credit", 32'(bus.credit), 4);
        exp_change_q.push_back(2);
        exp_vend_q.push_back(32'b0010);
        pay_confirm();
        cyc();
        chk("t2_stock1", stock_of(1), 2);
        chk("t2_short_count", 32'(sf_cnt), 1);

        // Drain item3, then a pre-paid selection of it must refund.
        for (int k = 0; k < 3; k++) begin
            select(4'b1000);
            coin(3);
            exp_change_q.push_back(0);
            exp_vend_q.push_back(32'b1000);
            pay_confirm();
            cyc();
        end
        chk("t3_stock3_empty", stock_of(3), 0);
        coin(4);
        chk("t3_prepay", 32'(bus.credit), 4);
        exp_change_q.push_back(4);
        select(4'b1000);
        chk("t3_sold_out", 32'(bus.sold_out), 1);
        cyc();
        chk("t3_sold_count", 32'(so_cnt), 1);
        chk("t3_credit_clr", 32'(bus.credit), 0);
        chk("t3_idle", 32'(bus.busy), 0);

        // Idle in PAY until the automatic refund.
        select(4'b0001);
        coin(3);
        exp_change_q.push_back(3);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < int'(TO) + 10) begin
            cyc();
            n++;
            if (bus.change_valid) seen = 1'b1;
        end
        chk("t4_refund_seen", 32'(seen), 1);
        chk("t4_timeout_window", 32'((n >= int'(TO)) && (n <= int'(TO) + 1)), 1);
        cyc();
        chk("t4_idle", 32'(bus.busy), 0);
        chk("t4_credit_clr", 32'(bus.credit), 0);

        // Overflowing coin is refused; cancel with a coin refunds only the held credit.
        coin(200);
        coin(50);
        chk("t5_credit", 32'(bus.credit), 250);
        coin(10);
        chk("t5_reject_count", 32'(cr_cnt), 1);
        chk("t5_credit_kept", 32'(bus.credit), 250);
        select(4'b0001);
        exp_change_q.push_back(250);
        bus.cancel     = 1'b1;
        bus.coin_valid = 1'b1;
        bus.coin_value = 8'd3;
        cyc();
        bus.cancel     = 1'b0;
        bus.coin_valid = 1'b0;
        chk("t5_refund_pulse", 32'(bus.change_valid), 1);
        cyc();
        chk("t5_credit_clr", 32'(bus.credit), 0);

        // Reset in the middle of payment: credit lost, stock reloaded.
        select(4'b0010);
        coin(5);
        reset = 1'b1;
        #1;
        chk("t6_rst_credit", 32'(bus.credit), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        cyc();
        reset = 1'b0;
        cyc();
        for (int i = 0; i < N; i++) chk("t6_rst_stock", stock_of(i), INIT);

        // Restock saturation and restock coinciding with the decrement.
        restock(0, 63);
        chk("t6_sat", stock_of(0), 63);
        select(4'b0001);
        coin(2);
        exp_change_q.push_back(0);
        exp_vend_q.push_back(32'b0001);
        pay_confirm();
        restock(0, 5);
        chk("t6_sat_vend", stock_of(0), 63);
        restock(1, 7);
        chk("t6_stock1_10", stock_of(1), 10);
        select(4'b0010);
        coin(2);
        exp_change_q.push_back(0);
        exp_vend_q.push_back(32'b0010);
        pay_confirm();
        restock(1, 5);
        chk("t6_restock_dec", stock_of(1), 14);
        cyc();

        chk("sb_change_left", 32'(exp_change_q.size()), 0);
        chk("sb_vend_left", 32'(exp_vend_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
